// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. It stalls PC and IF/ID and inserts a bubble into
//   ID/EX on a load-use hazard. On a taken branch it flushes IF/ID and ID/EX for
//   FLUSH_CYCLES consecutive cycles, starting in the branch cycle itself.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal issue; load-use stalls are honoured
//   FLUSH | trailing flush cycles after a taken branch; load-use ignored
//
// Parameters
//   FLUSH_CYCLES  flush length per taken branch (legal range 1..3)
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid, id_rs1, id_rs2   instruction currently in ID
//   ex_rd, ex_memread          destination and MemRead held in ID/EX
//   branch_taken               a branch resolved taken this cycle
//   pc_write, if_id_write      enables for the PC and the IF/ID register
//   if_id_flush, id_ex_flush   flush commands for IF/ID and ID/EX
//   stall_cnt, flush_cnt       saturating event counters, present only when
//                              the macro HAZARD_STATS_EN is defined
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] flush_left;
    logic [1:0] flush_left_nxt;
    logic       luh;
    logic       stall;

    assign luh = ex_memread && (ex_rd != 5'd0) && id_valid &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Stall only in RUN without a branch; a branch or a flush cycle wins.
    assign stall = rst_n && !branch_taken && (state == RUN) && luh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_left <= 2'd0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        if (branch_taken) begin
            // The branch cycle itself is the first flush cycle, so only
            // FLUSH_CYCLES-1 more remain; a branch during FLUSH reloads.
            if (FLUSH_CYCLES > 1) begin
                state_nxt      = FLUSH;
                flush_left_nxt = RELOAD;
            end else begin
                state_nxt      = RUN;
                flush_left_nxt = 2'd0;
            end
        end else if (state == FLUSH) begin
            if (flush_left <= 2'd1) begin
                state_nxt      = RUN;
                flush_left_nxt = 2'd0;
            end else begin
                flush_left_nxt = flush_left - 2'd1;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (branch_taken || (state == FLUSH)) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (branch_taken && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..3: the number of consecutive cycles for which IF/ID and ID/EX are flushed per taken branch.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port id_valid, input, 1 bit: the instruction in ID is real (not a bubble).
REQ-005 The block SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source register indices of the instruction in ID.
REQ-006 The block SHALL have port ex_rd, input, 5 bits: destination register held in the ID/EX register.
REQ-007 The block SHALL have port ex_memread, input, 1 bit: MemRead control held in the ID/EX register.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: a branch resolved taken this cycle.
REQ-009 The block SHALL have ports pc_write and if_id_write, output, 1 bit each: enables for the PC and IF/ID register.
REQ-010 The block SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: flush commands, with id_ex_flush driving the flush input of the ID/EX register.
REQ-011 The block SHALL have ports stall_cnt and flush_cnt, output, 16 bits each; these exist only when HAZARD_STATS_EN is defined.

Function
REQ-012 A load-use hazard (luh) SHALL be defined as: ex_memread=1, ex_rd!=0, id_valid=1, and ex_rd equals id_rs1 or id_rs2.
REQ-013 The state machine SHALL have exactly two states, RUN and FLUSH, plus a 2-bit counter flush_left.
REQ-014 All four control outputs SHALL be combinational, responding in the same cycle as the inputs to the state and the inputs, with no added latency.
REQ-015 When branch_taken=1, the state is FLUSH, or rst_n=0: if_id_flush SHALL be 1 and id_ex_flush SHALL be 1.
REQ-016 In RUN with branch_taken=0 and luh=1: pc_write=0, if_id_write=0, id_ex_flush=1 and if_id_flush=0 SHALL hold, inserting one bubble.
REQ-017 In RUN with branch_taken=0 and luh=0: pc_write=1, if_id_write=1 and both flushes=0 SHALL hold.
REQ-018 A branch SHALL take priority over luh: with branch_taken=1, pc_write=1 and if_id_write=1 regardless of luh.
REQ-019 In FLUSH: pc_write=1 and if_id_write=1 SHALL hold, and luh SHALL be ignored.
REQ-020 On branch_taken=1 in either state with FLUSH_CYCLES>1: next state SHALL be FLUSH and flush_left SHALL be set to FLUSH_CYCLES-1; a branch during FLUSH reloads the counter.
REQ-021 On branch_taken=1 with FLUSH_CYCLES=1: next state SHALL remain RUN.
REQ-022 In FLUSH with branch_taken=0: flush_left SHALL decrement; when flush_left=1, the next state SHALL be RUN with flush_left=0.
REQ-023 A taken branch in cycle n SHALL therefore produce flushes asserted in cycles n..n+FLUSH_CYCLES-1.
REQ-024 Repeated luh with no branch SHALL stall every cycle; the block adds no stall limit.

Reset
REQ-025 On rst_n low, asynchronously and regardless of clk: state SHALL be RUN, flush_left=0, stall_cnt=0, flush_cnt=0.
REQ-026 While rst_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
REQ-027 Reset asserted mid-FLUSH SHALL abort the sequence; after release, the first edge SHALL evaluate from RUN.

Configuration
REQ-028 With macro HAZARD_STATS_EN defined: stall_cnt SHALL increment on each edge where a REQ-016 stall is asserted, flush_cnt SHALL increment on each edge where branch_taken=1, both SHALL saturate at 16'hFFFF, and both SHALL be reset to 0.
REQ-029 With HAZARD_STATS_EN undefined: the counters and their ports SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Bench SHALL cover: ex_memread=1, ex_rd=5, id_rs2=5, id_valid=1, branch_taken=0 -> same cycle pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0; with HAZARD_STATS_EN, stall_cnt 0->1.
REQ-031 Bench SHALL cover: same as REQ-030 but ex_rd=0, or id_valid=0 -> pc_write=1, no flush.
REQ-032 Bench SHALL cover: FLUSH_CYCLES=2, one-cycle branch_taken pulse at cycle 10 -> both flushes =1 in cycles 10 and 11, =0 in cycle 12; flush_cnt=1.
REQ-033 Bench SHALL cover: FLUSH_CYCLES=3, branch_taken at cycles 10 and 11 -> flushes =1 in cycles 10 through 13.
REQ-034 Bench SHALL cover: branch_taken=1 together with luh=1 -> pc_write=1, if_id_write=1, both flushes=1, stall_cnt unchanged.
REQ-035 Bench SHALL cover: rst_n dropped asynchronously at cycle 11 of a FLUSH sequence -> outputs immediately reset-valued, counters 0, and RUN behaviour on the first edge after release.
